// File: rtl/rs_enc_32_28_pkg.sv
// Shared constants for the RS(32,28) encoder.
//   - GF(2^8) field polynomial and a multiply-by-alpha helper
//   - generator polynomial coefficients g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0
//   - frame geometry and FSM state encodings
package rs_enc_32_28_pkg;

   localparam int N_DATA = 28;
   localparam int N_PAR  = 4;
   localparam int RS_K   = N_DATA;
   localparam int RS_N   = N_DATA + N_PAR;

   localparam logic [8:0] GF_POLY = 9'h11D;

   // g(x) = (x+1)(x+a)(x+a^2)(x+a^3)
   localparam logic [7:0] G3 = 8'h0F;
   localparam logic [7:0] G2 = 8'h36;
   localparam logic [7:0] G1 = 8'h78;
   localparam logic [7:0] G0 = 8'h40;

   // Indexed so that G_COEF[i] multiplies into LFSR stage r_i.
   localparam logic [3:0][7:0] G_COEF = {G3, G2, G1, G0};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_PAR  = 2'd2;

   // Multiply a field element by alpha (x), reducing modulo GF_POLY.
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      gf_xtime = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
   endfunction

endpackage

// File: rtl/rs_enc_32_28_gf256.sv
// GF(2^8) multiply-accumulate: y = (a * b) + c over the 0x11D field.
// Ports:
//   a  in  8  multiplicand
//   b  in  8  multiplier (constant in the encoder, so the logic folds down)
//   c  in  8  addend (field addition is XOR)
//   y  out 8  result
module rs_enc_32_28_gf256
   import rs_enc_32_28_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   output logic [7:0] y
);

   logic [7:0] a_pow;
   logic [7:0] acc;

   // Shift-and-add: a_pow walks through a*x^i, accumulated where b has a 1.
   always_comb begin
      a_pow = a;
      acc   = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            acc = acc ^ a_pow;
         end
         a_pow = gf_xtime(a_pow);
      end
   end

   assign y = acc ^ c;

endmodule

// File: rtl/rs_enc_32_28.sv
// Byte-serial systematic RS(32,28) encoder over GF(2^8).
// Passes 28 message bytes straight through, then appends the 4 parity bytes
// held in a generator-division LFSR (r3 first, r0 last).
// Ports:
//   i_clk    in  1  clock, rising edge
//   i_resb   in  1  synchronous active-high reset
//   i_data   in  8  message byte, highest-degree coefficient first
//   i_valid  in  1  i_data valid
//   i_sof    in  1  first byte of a frame (qualified by i_valid)
//   o_ready  out 1  input byte is accepted this cycle when i_valid is high
//   o_data   out 8  registered codeword byte
//   o_valid  out 1  o_data valid
//   o_sof    out 1  first codeword byte
//   o_eof    out 1  last parity byte
//   i_ready  in  1  downstream accepts o_data
//   o_err    out 1  one-cycle pulse on a dropped or frame-aborting byte
module rs_enc_32_28
   import rs_enc_32_28_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_resb,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   input  logic       i_sof,
   output logic       o_ready,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_sof,
   output logic       o_eof,
   input  logic       i_ready,
   output logic       o_err
);

   logic [1:0] state_reg, state_next;
   logic [4:0] count_reg, count_next;
   logic [1:0] par_idx_reg, par_idx_next;
   logic [7:0] lfsr_reg  [N_PAR];
   logic [7:0] lfsr_next [N_PAR];
   logic [7:0] lfsr_upd  [N_PAR];
   logic [7:0] data_reg, data_next;
   logic       valid_reg, valid_next;
   logic       sof_reg, sof_next;
   logic       eof_reg, eof_next;
   logic       err_reg, err_next;

   logic       advance;
   logic       accept;
   logic [7:0] fb;

   assign advance = !valid_reg | i_ready;
   assign o_ready = (state_reg != S_PAR) & advance;
   assign accept  = i_valid & o_ready;

   // A sof byte always starts division from a zero remainder, whether it
   // opens a frame from idle or aborts a partial one.
   assign fb = i_data ^ (i_sof ? 8'h00 : lfsr_reg[N_PAR-1]);

   for (genvar gi = 0; gi < N_PAR; gi++) begin : g_lfsr
      logic [7:0] carry;
      if (gi == 0) begin : g_low
         assign carry = 8'h00;
      end else begin : g_high
         assign carry = i_sof ? 8'h00 : lfsr_reg[gi-1];
      end
      rs_enc_32_28_gf256 u_mac (
         .a (fb),
         .b (G_COEF[gi]),
         .c (carry),
         .y (lfsr_upd[gi])
      );
   end

   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      par_idx_next = par_idx_reg;
      lfsr_next    = lfsr_reg;
      data_next    = data_reg;
      valid_next   = valid_reg;
      sof_next     = sof_reg;
      eof_next     = eof_reg;
      err_next     = 1'b0;

      // Output slot drains unless something below refills it.
      if (advance) begin
         valid_next = 1'b0;
         sof_next   = 1'b0;
         eof_next   = 1'b0;
      end

      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               if (i_sof) begin
                  data_next  = i_data;
                  valid_next = 1'b1;
                  sof_next   = 1'b1;
                  eof_next   = 1'b0;
                  lfsr_next  = lfsr_upd;
                  count_next = 5'd1;
                  state_next = S_DATA;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               data_next  = i_data;
               valid_next = 1'b1;
               eof_next   = 1'b0;
               lfsr_next  = lfsr_upd;
               if (i_sof) begin
                  err_next   = 1'b1;
                  sof_next   = 1'b1;
                  count_next = 5'd1;
               end else begin
                  sof_next   = 1'b0;
                  count_next = count_reg + 5'd1;
                  if (count_reg == 5'(N_DATA - 1)) begin
                     state_next   = S_PAR;
                     par_idx_next = 2'd0;
                  end
               end
            end
         end
         S_PAR: begin
            if (advance) begin
               data_next    = lfsr_reg[N_PAR-1];
               valid_next   = 1'b1;
               sof_next     = 1'b0;
               eof_next     = (par_idx_reg == 2'(N_PAR - 1));
               par_idx_next = par_idx_reg + 2'd1;
               lfsr_next[0] = 8'h00;
               for (int i = 1; i < N_PAR; i++) begin
                  lfsr_next[i] = lfsr_reg[i-1];
               end
               if (par_idx_reg == 2'(N_PAR - 1)) begin
                  state_next = S_IDLE;
                  count_next = 5'd0;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_resb) begin
         state_reg   <= S_IDLE;
         count_reg   <= 5'd0;
         par_idx_reg <= 2'd0;
         for (int i = 0; i < N_PAR; i++) begin
            lfsr_reg[i] <= 8'h00;
         end
         data_reg  <= 8'h00;
         valid_reg <= 1'b0;
         sof_reg   <= 1'b0;
         eof_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         par_idx_reg <= par_idx_next;
         for (int i = 0; i < N_PAR; i++) begin
            lfsr_reg[i] <= lfsr_next[i];
         end
         data_reg  <= data_next;
         valid_reg <= valid_next;
         sof_reg   <= sof_next;
         eof_reg   <= eof_next;
         err_reg   <= err_next;
      end
   end

   assign o_data  = data_reg;
   assign o_valid = valid_reg;
   assign o_sof   = sof_reg;
   assign o_eof   = eof_reg;
   assign o_err   = err_reg;

endmodule

// File: doc/rs_enc_32_28.md
Name: rs_enc_32_28

Overview:
- Byte-serial systematic RS(32,28) encoder over GF(2^8), primitive polynomial 0x11D, alpha = 0x02.
- Generator is g(x) = (x+1)(x+a)(x+a^2)(x+a^3) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40, with roots matching the decoder syndromes S0..S3.
- Passes 28 message bytes through unchanged, then appends 4 parity bytes from an LFSR.
- Sits on the transmit/test side and feeds rs_dec frames for loopback and bench stimulus.

Parameters:
- N_DATA, 28, message bytes per frame.
- N_PAR, 4, parity bytes per frame. Fixed; the generator coefficients are only valid for 4.

Ports:
- i_clk  in  1  clock, rising edge.
- i_resb  in  1  reset, synchronous, active-high (name kept per codebase; polarity and synchronicity fixed).
- i_data  in  8  message byte, highest-degree coefficient first.
- i_valid  in  1  i_data valid.
- i_sof  in  1  qualifies first byte of a frame; sampled with i_valid.
- o_ready  out  1  encoder accepts the input byte this cycle.
- o_data  out  8  codeword byte (registered).
- o_valid  out  1  o_data valid.
- o_sof  out  1  with first codeword byte.
- o_eof  out  1  with last parity byte (p0).
- i_ready  in  1  downstream accepts o_data.
- o_err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (i_resb=1 at an edge):
  - state=S_IDLE, count=0, LFSR r3..r0=0.
  - o_data=0, o_valid=0, o_sof=0, o_eof=0, o_err=0.
  - Reset mid-frame discards the frame with no output.
- Accept: byte accepted when i_valid & o_ready.
- Advance: output register loads when !o_valid | i_ready.
- o_ready = (state != S_PAR) & (!o_valid | i_ready).
- LFSR per accepted data byte:
  - f = i_data ^ r3
  - r3 <= r2 ^ f*0x0F
  - r2 <= r1 ^ f*0x36
  - r1 <= r0 ^ f*0x78
  - r0 <= f*0x40
- S_IDLE:
  - Waits for an accepted byte with i_sof=1. Bytes without i_sof are dropped and pulse o_err.
  - On the sof byte: LFSR is computed from a zero state, o_data <= i_data, o_sof=1, count=1, go to S_DATA.
- S_DATA:
  - Each accepted byte: pass-through to o_data, update LFSR, count++.
  - On the 28th byte (count reaching 28): go to S_PAR, parity index=0.
  - An accepted byte with i_sof=1 here aborts the frame: o_err pulse, LFSR restarts with that byte as byte 1, count=1, o_sof=1. The partial frame is not completed.
- S_PAR:
  - o_ready=0. Each output advance emits r3, then shifts (r3<=r2, r2<=r1, r1<=r0, r0<=0).
  - Emits 4 bytes. o_eof=1 on the 4th, then go to S_IDLE.
- Latency: 1 cycle from accept to o_valid.
- Back-to-back frames: the next sof byte is accepted in the cycle after p0 is loaded, giving a 4-cycle input bubble per frame (28 in / 32 out).
- o_data, o_sof, o_eof hold stable while o_valid & !i_ready.
- Simultaneous advance and accept on the last data byte: the LFSR uses the post-byte value, and the first parity emits on the next advance.
- o_err has no effect on o_valid.

Decomposition:
- Shared include rs_defines.vh holds:
  - GF_POLY=0x11D
  - G3=0x0F, G2=0x36, G1=0x78, G0=0x40
  - RS_N=32, RS_K=28
  - state encodings S_IDLE/S_DATA/S_PAR
- Constant multiplies reuse the existing gf256_mult (4 instances, B tied to constants) and gf256_sum.
- No new sub-module; the LFSR and FSM stay in rs_enc_32_28.

Test Plan:
- All-zero message, sof on byte 0, i_ready=1 -> 32 outputs all 0x00; o_sof on the 1st output, o_eof on the 32nd.
- Bytes 0..26=0x00, byte 27=0x01 -> parity 0x0F, 0x36, 0x78, 0x40 in order.
- Same frame with byte 27=0x02 -> parity 0x1E, 0x6C, 0xF0, 0x80 (linearity check).
- Random 28-byte message, then loopback of the 32 outputs into rs_dec syndrome + rs_dec_euclid_alg -> all syndromes 0x00.
- Random i_ready toggling -> the same 32 bytes as with i_ready=1. o_data held stable while stalled. o_ready=0 during all 4 parity slots.
- i_sof asserted at byte 10; separately, i_resb pulsed at byte 15 -> o_err pulse and frame restarts with count=1. After reset: o_valid=0 next cycle, and a fresh frame encodes correctly.
